// File: rtl/tdcpu_pkg.sv
// tdcpu_pkg: shared definitions for the tdcpu core.
// Holds the opcode encodings, the ALU Y-operand select encoding and the
// run/halt state enum. The HALT opcode (1101) only halts when TDCPU_HALT_EN
// is defined; otherwise it decodes as a NOP.
package tdcpu_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_HALT   = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  // ALU Y-operand source
  typedef enum logic [1:0] {
    Y_A    = 2'd0,
    Y_B    = 2'd1,
    Y_IN   = 2'd2,
    Y_ZERO = 2'd3
  } ysel_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/tdcpu_decoder.sv
// tdcpu_decoder: combinational instruction decoder.
// Ports: opcode (instruction opcode), c (current carry flag) ->
//   ld_a/ld_b (register load), ld_out (output load), ld_pc (jump taken),
//   y_sel (ALU Y source), is_halt (HALT opcode, only with TDCPU_HALT_EN).
module tdcpu_decoder
  import tdcpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       c,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       ld_pc,
  output ysel_t      y_sel,
  output logic       is_halt
);

  // Opcode to control mapping; unlisted opcodes are NOPs with Y=0
  always_comb begin
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_out  = 1'b0;
    ld_pc   = 1'b0;
    y_sel   = Y_ZERO;
    is_halt = 1'b0;
    case (opcode)
      OP_ADD_A:  begin ld_a = 1'b1; y_sel = Y_A;    end
      OP_MOV_AB: begin ld_a = 1'b1; y_sel = Y_B;    end
      OP_IN_A:   begin ld_a = 1'b1; y_sel = Y_IN;   end
      OP_MOV_AI: begin ld_a = 1'b1; y_sel = Y_ZERO; end
      OP_MOV_BA: begin ld_b = 1'b1; y_sel = Y_A;    end
      OP_ADD_B:  begin ld_b = 1'b1; y_sel = Y_B;    end
      OP_IN_B:   begin ld_b = 1'b1; y_sel = Y_IN;   end
      OP_MOV_BI: begin ld_b = 1'b1; y_sel = Y_ZERO; end
      OP_OUT_B:  begin ld_out = 1'b1; y_sel = Y_B;    end
      OP_OUT_I:  begin ld_out = 1'b1; y_sel = Y_ZERO; end
      OP_JNC:    ld_pc = ~c;
      OP_JMP:    ld_pc = 1'b1;
`ifdef TDCPU_HALT_EN
      OP_HALT:   is_halt = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/tdcpu_core.sv
// tdcpu_core: parametrised TD4-style processor, one instruction per clock.
// Ports: CK/RST (clock, sync active-high reset), IADDR/IDATA (instruction
//   ROM address and word), IN_PORT (input port), OUT_DATA/OUT_VALID/OUT_READY
//   (output register with valid/ready handshake), CFLAG (carry), HALTED.
// Optional feature: define TDCPU_HALT_EN to make opcode 1101 a HALT.
module tdcpu_core
  import tdcpu_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                CK,
  input  logic                RST,
  output logic [ADDR_W-1:0]   IADDR,
  input  logic [DATA_W+3:0]   IDATA,
  input  logic [DATA_W-1:0]   IN_PORT,
  output logic [DATA_W-1:0]   OUT_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                CFLAG,
  output logic                HALTED
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              c_q;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] im;
  logic              ld_a, ld_b, ld_out, ld_pc, is_halt;
  ysel_t             y_sel;
  logic [DATA_W-1:0] y;
  logic [SUM_W-1:0]  sum;
  logic              stall, running, exec;

  assign opcode = IDATA[DATA_W+3:DATA_W];
  assign im     = IDATA[DATA_W-1:0];

  tdcpu_decoder u_decoder (
    .opcode  (opcode),
    .c       (c_q),
    .ld_a    (ld_a),
    .ld_b    (ld_b),
    .ld_out  (ld_out),
    .ld_pc   (ld_pc),
    .y_sel   (y_sel),
    .is_halt (is_halt)
  );

  // ALU Y-operand mux
  always_comb begin
    y = '0;
    case (y_sel)
      Y_A:     y = a_q;
      Y_B:     y = b_q;
      Y_IN:    y = IN_PORT;
      default: y = '0;
    endcase
  end

  assign sum = {1'b0, y} + {1'b0, im};

  // An OUT stalls only while an unconsumed value is not being taken this edge
  assign stall = ld_out & OUT_VALID & ~OUT_READY;

`ifdef TDCPU_HALT_EN
  state_t state_q, state_d;

  // Run/halt state register
  always_ff @(posedge CK) begin
    if (RST) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state: HALT is left only through reset
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && is_halt) state_d = ST_HALT;
  end

  assign running = (state_q == ST_RUN);
  assign HALTED  = (state_q == ST_HALT);
`else
  assign running = 1'b1;
  assign HALTED  = 1'b0;
`endif

  // The HALT instruction itself changes nothing but the state
  assign exec = running & ~is_halt & ~stall;

  // Architectural state and output handshake
  always_ff @(posedge CK) begin
    if (RST) begin
      pc_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      if (exec) begin
        if (ld_a) a_q <= sum[DATA_W-1:0];
        if (ld_b) b_q <= sum[DATA_W-1:0];
        c_q  <= sum[DATA_W];
        pc_q <= ld_pc ? im[ADDR_W-1:0] : pc_q + ADDR_W'(1);
      end
      if (exec && ld_out) begin
        OUT_DATA  <= sum[DATA_W-1:0];
        OUT_VALID <= 1'b1;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

  assign IADDR = pc_q;
  assign CFLAG = c_q;

endmodule

// File: tb/tb_tdcpu_core.sv
// tb_tdcpu_core: directed self-checking bench for tdcpu_core (4-bit data,
// 4-bit address). The instruction ROM is a bench array read combinationally.
module tb_tdcpu_core;

  logic       CK;
  logic       RST;
  logic [3:0] IADDR;
  logic [7:0] IDATA;
  logic [3:0] IN_PORT;
  logic [3:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       CFLAG;
  logic       HALTED;

  logic [7:0] rom [16];
  logic       use_rand;
  logic [7:0] rand_word;
  int         n_checks;
  int         n_fail;

  tdcpu_core #(.DATA_W(4), .ADDR_W(4)) dut (
    .CK        (CK),
    .RST       (RST),
    .IADDR     (IADDR),
    .IDATA     (IDATA),
    .IN_PORT   (IN_PORT),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .CFLAG     (CFLAG),
    .HALTED    (HALTED)
  );

  assign IDATA = use_rand ? rand_word : rom[IADDR];

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  function automatic logic [7:0] ins(input logic [3:0] op, input logic [3:0] im);
    return {op, im};
  endfunction

  task automatic step();
    @(posedge CK);
    @(negedge CK);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = ins(4'h8, 4'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    use_rand = 1'b1;
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_word = 8'($urandom);
      step();
    end
    RST = 1'b0;
    n_checks++; if (IADDR !== 4'd0)    begin n_fail++; $display("FAIL reset_iaddr got %0d want 0", IADDR); end
    n_checks++; if (OUT_DATA !== 4'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", OUT_DATA); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    n_checks++; if (CFLAG !== 1'b0)    begin n_fail++; $display("FAIL reset_cflag got %b want 0", CFLAG); end
    n_checks++; if (HALTED !== 1'b0)   begin n_fail++; $display("FAIL reset_halted got %b want 0", HALTED); end
    use_rand = 1'b0;
  endtask

  task automatic test_carry_jnc();
    fill_nop();
    rom[0] = ins(4'h3, 4'hF);  // MOV A,15
    rom[1] = ins(4'h0, 4'h1);  // ADD A,1 -> A=0, C=1
    rom[2] = ins(4'hE, 4'h0);  // JNC 0, not taken
    rom[3] = ins(4'h4, 4'h6);  // MOV B,A+6 -> 6
    rom[4] = ins(4'h9, 4'h0);  // OUT B
    OUT_READY = 1'b1;
    do_reset();
    step();
    n_checks++; if (CFLAG !== 1'b0)  begin n_fail++; $display("FAIL mov_cflag got %b want 0", CFLAG); end
    step();
    n_checks++; if (CFLAG !== 1'b1)  begin n_fail++; $display("FAIL add_carry got %b want 1", CFLAG); end
    n_checks++; if (IADDR !== 4'd2)  begin n_fail++; $display("FAIL add_iaddr got %0d want 2", IADDR); end
    step();
    n_checks++; if (IADDR !== 4'd3)  begin n_fail++; $display("FAIL jnc_not_taken got %0d want 3", IADDR); end
    n_checks++; if (CFLAG !== 1'b0)  begin n_fail++; $display("FAIL jnc_clears_c got %b want 0", CFLAG); end
    step();
    step();
    n_checks++; if (OUT_DATA !== 4'd6) begin n_fail++; $display("FAIL a_after_wrap got %0d want 6", OUT_DATA); end
    n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL carry_out_valid got %b want 1", OUT_VALID); end
  endtask

  task automatic test_jump();
    fill_nop();
    rom[0] = ins(4'hE, 4'h6);  // JNC 6, taken (C=0)
    rom[6] = ins(4'hF, 4'h2);  // JMP 2
    do_reset();
    step();
    n_checks++; if (IADDR !== 4'd6) begin n_fail++; $display("FAIL jnc_taken got %0d want 6", IADDR); end
    step();
    n_checks++; if (IADDR !== 4'd2) begin n_fail++; $display("FAIL jmp got %0d want 2", IADDR); end
    step();
    n_checks++; if (IADDR !== 4'd3) begin n_fail++; $display("FAIL after_jmp got %0d want 3", IADDR); end
  endtask

  task automatic test_alu();
    fill_nop();
    rom[0] = ins(4'h2, 4'h8);  // IN A+8 -> 17 -> A=1, C=1
    rom[1] = ins(4'h4, 4'h0);  // MOV B,A -> B=1
    rom[2] = ins(4'h9, 4'h0);  // OUT B -> 1
    rom[3] = ins(4'h6, 4'h3);  // IN B+3 -> 12
    rom[4] = ins(4'h5, 4'h5);  // ADD B,5 -> 17 -> B=1, C=1
    rom[5] = ins(4'h1, 4'h2);  // MOV A,B+2 -> 3
    rom[6] = ins(4'h4, 4'h0);  // MOV B,A -> 3
    rom[7] = ins(4'h9, 4'h4);  // OUT B+4 -> 7
    IN_PORT = 4'd9;
    OUT_READY = 1'b1;
    do_reset();
    step();
    n_checks++; if (CFLAG !== 1'b1) begin n_fail++; $display("FAIL in_a_carry got %b want 1", CFLAG); end
    step();
    step();
    n_checks++; if (OUT_DATA !== 4'd1) begin n_fail++; $display("FAIL in_a_result got %0d want 1", OUT_DATA); end
    step();
    step();
    n_checks++; if (CFLAG !== 1'b1) begin n_fail++; $display("FAIL add_b_carry got %b want 1", CFLAG); end
    step();
    step();
    step();
    n_checks++; if (OUT_DATA !== 4'd7) begin n_fail++; $display("FAIL alu_chain got %0d want 7", OUT_DATA); end
  endtask

  task automatic test_output();
    fill_nop();
    rom[0] = ins(4'h7, 4'h3);  // MOV B,3
    rom[1] = ins(4'h9, 4'h2);  // OUT B+2
    OUT_READY = 1'b1;
    do_reset();
    step();
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL out_valid_early got %b want 0", OUT_VALID); end
    step();
    n_checks++; if (OUT_DATA !== 4'd5)  begin n_fail++; $display("FAIL out_b_data got %0d want 5", OUT_DATA); end
    n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL out_valid_rise got %b want 1", OUT_VALID); end
    step();
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL out_valid_drop got %b want 0", OUT_VALID); end
  endtask

  task automatic test_backpressure();
    fill_nop();
    rom[0] = ins(4'hB, 4'h7);  // OUT 7
    rom[1] = ins(4'hB, 4'h9);  // OUT 9
    OUT_READY = 1'b0;
    do_reset();
    step();
    n_checks++; if (OUT_DATA !== 4'd7) begin n_fail++; $display("FAIL bp_first got %0d want 7", OUT_DATA); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (IADDR !== 4'd1)    begin n_fail++; $display("FAIL bp_hold_iaddr cyc %0d got %0d want 1", i, IADDR); end
      n_checks++; if (OUT_DATA !== 4'd7) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got %0d want 7", i, OUT_DATA); end
      n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", i, OUT_VALID); end
    end
    OUT_READY = 1'b1;
    step();
    n_checks++; if (OUT_DATA !== 4'd9)  begin n_fail++; $display("FAIL bp_release_data got %0d want 9", OUT_DATA); end
    n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid got %b want 1", OUT_VALID); end
    n_checks++; if (IADDR !== 4'd2)     begin n_fail++; $display("FAIL bp_release_iaddr got %0d want 2", IADDR); end
    step();
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", OUT_VALID); end
  endtask

  task automatic test_nonout_no_stall();
    fill_nop();
    rom[0] = ins(4'hB, 4'h4);  // OUT 4, then NOPs with READY low
    OUT_READY = 1'b0;
    do_reset();
    step();
    step();
    step();
    n_checks++; if (IADDR !== 4'd3)     begin n_fail++; $display("FAIL nop_no_stall got %0d want 3", IADDR); end
    n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL valid_held got %b want 1", OUT_VALID); end
    OUT_READY = 1'b1;
    step();
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL valid_consumed got %b want 0", OUT_VALID); end
  endtask

  task automatic test_wrap();
    fill_nop();
    rom[3]  = ins(4'hA, 4'h5);
    rom[9]  = ins(4'hC, 4'hF);
    rom[12] = ins(4'hA, 4'h0);
    do_reset();
    n_checks++; if (IADDR !== 4'd0) begin n_fail++; $display("FAIL wrap_start got %0d want 0", IADDR); end
    for (int i = 1; i <= 16; i++) begin
      step();
      n_checks++; if (IADDR !== 4'(i)) begin n_fail++; $display("FAIL wrap_iaddr step %0d got %0d want %0d", i, IADDR, 4'(i)); end
    end
  endtask

`ifdef TDCPU_HALT_EN
  task automatic test_halt();
    fill_nop();
    rom[5] = ins(4'hD, 4'h0);
    OUT_READY = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (IADDR !== 4'd5)  begin n_fail++; $display("FAIL halt_reach got %0d want 5", IADDR); end
    n_checks++; if (HALTED !== 1'b0) begin n_fail++; $display("FAIL halt_early got %b want 0", HALTED); end
    step();
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (IADDR !== 4'd5)  begin n_fail++; $display("FAIL halt_iaddr cyc %0d got %0d want 5", i, IADDR); end
      n_checks++; if (HALTED !== 1'b1) begin n_fail++; $display("FAIL halt_flag cyc %0d got %b want 1", i, HALTED); end
      step();
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_checks++; if (IADDR !== 4'd0)  begin n_fail++; $display("FAIL halt_rst_iaddr got %0d want 0", IADDR); end
    n_checks++; if (HALTED !== 1'b0) begin n_fail++; $display("FAIL halt_rst_flag got %b want 0", HALTED); end
  endtask
`else
  task automatic test_halt_disabled();
    fill_nop();
    rom[5] = ins(4'hD, 4'h0);
    do_reset();
    for (int i = 0; i < 7; i++) step();
    n_checks++; if (IADDR !== 4'd7)  begin n_fail++; $display("FAIL halt_as_nop got %0d want 7", IADDR); end
    n_checks++; if (HALTED !== 1'b0) begin n_fail++; $display("FAIL halted_tied got %b want 0", HALTED); end
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RST       = 1'b1;
    OUT_READY = 1'b0;
    IN_PORT   = 4'd0;
    use_rand  = 1'b1;
    rand_word = 8'h00;
    fill_nop();
    test_reset();
    test_carry_jnc();
    test_jump();
    test_alu();
    test_output();
    test_backpressure();
    test_nonout_no_stall();
    test_wrap();
`ifdef TDCPU_HALT_EN
    test_halt();
`else
    test_halt_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
